// File: rtl/jkff_pkg.sv
// Shared JK encodings, default counter width and the next-state rule.
package jkff_pkg;
    localparam logic [1:0] JK_HOLD = 2'b00;
    localparam logic [1:0] JK_RST  = 2'b01;
    localparam logic [1:0] JK_SET  = 2'b10;
    localparam logic [1:0] JK_TGL  = 2'b11;

    localparam int CNT_W_DEF = 16;

    function automatic logic jk_next(input logic [1:0] jk, input logic q);
        logic n;
        case (jk)
            JK_RST:  n = 1'b0;
            JK_SET:  n = 1'b1;
            JK_TGL:  n = ~q;
            default: n = q;
        endcase
        return n;
    endfunction
endpackage

// File: rtl/jkff_toggle_cnt.sv
// Saturating activity counter; clear wins over increment.
module jkff_toggle_cnt
    import jkff_pkg::*;
#(
    parameter int W = CNT_W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt,
    output logic         sat
);
    assign sat = &cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (inc && !sat)
            cnt <= cnt + W'(1);
    end
endmodule

// File: rtl/jkff.sv
// JK flip-flop with an optional toggle-activity counter,
// built only when JKFF_TOGGLE_CNT_EN is defined.
module jkff
    import jkff_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       jk,
    input  logic             cnt_clr,
    output logic             q,
    output logic             qb,
    output logic [CNT_W-1:0] tgl_cnt,
    output logic             tgl_sat
);
    logic q_nxt;

    assign q_nxt = jk_next(jk, q);
    assign qb    = ~q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            q <= 1'b0;
        else
            q <= q_nxt;
    end

`ifdef JKFF_TOGGLE_CNT_EN
    logic tgl;

    assign tgl = q_nxt ^ q;

    jkff_toggle_cnt #(.W(CNT_W)) u_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .inc (tgl),
        .cnt (tgl_cnt),
        .sat (tgl_sat)
    );
`else
    logic unused_clr;

    assign unused_clr = cnt_clr;
    assign tgl_cnt    = '0;
    assign tgl_sat    = 1'b0;
`endif
endmodule

// File: tb/tb_jkff.sv
// Randomised scoreboard bench for jkff: stimulus pushes expectations, a monitor
// pops and compares after each clock edge.
module tb_jkff;
    localparam int W   = 4;
    localparam int MAX = (1 << W) - 1;
`ifdef JKFF_TOGGLE_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    typedef struct {
        logic q;
        int   cnt;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [1:0]   jk;
    logic         cnt_clr;
    logic         q, qb;
    logic [W-1:0] tgl_cnt;
    logic         tgl_sat;

    int checks = 0;
    int errors = 0;

    exp_t exp_q[$];
    int   m_q;
    int   m_cnt;

    jkff #(.CNT_W(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .jk      (jk),
        .cnt_clr (cnt_clr),
        .q       (q),
        .qb      (qb),
        .tgl_cnt (tgl_cnt),
        .tgl_sat (tgl_sat)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, req, $time);
        end
    endtask

    task automatic chk_all(input string nm, input exp_t e);
        chk({nm, ".q"}, 32'(q), 32'(e.q));
        chk({nm, ".qb"}, 32'(qb), 32'(!e.q));
        chk({nm, ".cnt"}, 32'(tgl_cnt), 32'(e.cnt));
        chk({nm, ".sat"}, 32'(tgl_sat), 32'(e.cnt == MAX));
    endtask

    // Reference: J/K rules in plain terms, counter as a clipped integer.
    task automatic model_edge(input logic [1:0] v, input logic c);
        int j, k, nq;
        exp_t e;
        j = int'(v[1]);
        k = int'(v[0]);
        if (j == 1 && k == 1)  nq = 1 - m_q;
        else if (j == 1)       nq = 1;
        else if (k == 1)       nq = 0;
        else                   nq = m_q;
        if (CNT_EN) begin
            if (c)             m_cnt = 0;
            else if (nq != m_q) m_cnt = (m_cnt + 1 > MAX) ? MAX : m_cnt + 1;
        end
        m_q   = nq;
        e.q   = m_q[0];
        e.cnt = m_cnt;
        exp_q.push_back(e);
    endtask

    task automatic step(input logic [1:0] v, input logic c);
        @(negedge clk);
        jk      = v;
        cnt_clr = c;
        model_edge(v, c);
    endtask

    task automatic model_reset();
        m_q   = 0;
        m_cnt = 0;
    endtask

    // Monitor: one expectation per clock edge while the queue holds one.
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk_all("edge", e);
            end
        end
    end

    initial begin : stim
        exp_t r;
        r.q   = 1'b0;
        r.cnt = 0;
        rst     = 1'b1;
        jk      = 2'b11;
        cnt_clr = 1'b0;
        model_reset();
        #1;
        chk_all("reset_async", r);
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset_held", r);
        @(negedge clk);
        rst = 1'b0;

        step(2'b01, 1'b0);
        step(2'b10, 1'b0);
        step(2'b11, 1'b0);
        step(2'b00, 1'b0);
        repeat (5) step(2'b11, 1'b0);

        // jk glitches mid-cycle; only the value present at the edge counts
        @(negedge clk);
        jk = 2'b01; #1 jk = 2'b10; #1 jk = 2'b01;
        cnt_clr = 1'b0;
        model_edge(2'b01, 1'b0);
        @(negedge clk);
        jk = 2'b10; #1 jk = 2'b01; #1 jk = 2'b10;
        model_edge(2'b10, 1'b0);

        repeat (20) step(2'b11, 1'b0);
        step(2'b11, 1'b1);

        for (int i = 0; i < 200; i++)
            step(2'($urandom_range(0, 3)), ($urandom_range(0, 15) == 0));

        // reach q=1, count 7, then reset mid clock-low
        step(2'b01, 1'b1);
        repeat (7) step(2'b11, 1'b0);
        @(negedge clk);
        jk = 2'b00;
        #2 rst = 1'b1;
        model_reset();
        #1;
        chk_all("reset_mid", r);
        for (int i = 0; i < 2; i++) begin
            jk      = 2'b10;
            cnt_clr = 1'b0;
            @(posedge clk);
            #1;
            chk_all("reset_ignore", r);
        end
        @(negedge clk);
        rst = 1'b0;
        step(2'b10, 1'b0);
        for (int i = 0; i < 60; i++)
            step(2'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0));

        // drain with a bounded wait
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain actual=%0d required=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
